pixel_stream_proc: RTL and testbench
====================================

Name: pixel_stream_proc

Overview:
Parametrised streaming pixel processor between the image reader and image writer.
- Accepts PIX_PER_CLK RGB pixels per beat, qualified by HSYNC_IN.
- Applies one per-frame-selectable point operation: pass, brighten, darken, invert, threshold or grayscale.
- Emits the result with fixed two-cycle latency.
- Tracks line and column position, and flags frame completion and framing errors.

Parameters:
DATA_W, 8, bits per colour component
PIX_PER_CLK, 2, pixels per beat (≥1)
WIDTH, 768, pixels per line (must be a multiple of PIX_PER_CLK)
HEIGHT, 512, lines per frame
LAT, 2, pipeline latency in cycles (fixed; not overridable)

Ports:
HCLK  in  1  clock, rising edge
HRESETn  in  1  asynchronous active-low reset
mode  in  3  operation select: 0 pass, 1 add-sat, 2 sub-sat, 3 invert, 4 threshold, 5 gray; 6–7 behave as pass
value  in  DATA_W  operand for add/sub/threshold
VSYNC_IN  in  1  frame-start pulse
HSYNC_IN  in  1  beat valid
DATA_R_IN/DATA_G_IN/DATA_B_IN  in  PIX_PER_CLK*DATA_W each  packed pixels; pixel k occupies bits [k*DATA_W +: DATA_W]
HSYNC_OUT  out  1  output beat valid
DATA_R_OUT/DATA_G_OUT/DATA_B_OUT  out  PIX_PER_CLK*DATA_W each  processed pixels, same packing
line_cnt  out  clog2(HEIGHT)  current input line
col_cnt  out  clog2(WIDTH/PIX_PER_CLK)  current input beat within line
busy  out  1  high in ACTIVE or DRAIN
frame_done  out  1  one-cycle pulse at end of frame
frame_err  out  1  sticky framing error

Behaviour:
- Reset (async, HRESETn low): all outputs 0, counters 0, state IDLE, pipeline valids cleared. Data outputs are held at 0.
- States:
  - IDLE: wait for VSYNC_IN. On VSYNC_IN, latch mode and value into shadow registers, clear counters and frame_err, go to ARMED.
  - ARMED: on HSYNC_IN, go to ACTIVE and count that beat. A second VSYNC_IN re-latches mode and value and stays in ARMED.
  - ACTIVE: each HSYNC_IN beat increments col_cnt. At beat WIDTH/PIX_PER_CLK-1, col_cnt wraps to 0 and line_cnt increments. When the last beat of line HEIGHT-1 is accepted, go to DRAIN.
  - DRAIN: wait LAT cycles, then go to DONE.
  - DONE: assert frame_done for 1 cycle, then return to IDLE.
- mode and value changes outside the latch point are ignored for the current frame.
- Gaps (HSYNC_IN low) in ACTIVE are allowed. Counters hold, and no output beat is produced.
- Pipeline:
  - Stage 1 registers the inputs, the valid bit and the luma sum Y=(R+2G+B)>>2, computed at DATA_W+2 bits and truncated to DATA_W.
  - Stage 2 computes and registers the result.
  - HSYNC_OUT equals HSYNC_IN delayed by exactly 2 cycles.
  - When HSYNC_OUT is low, data outputs hold their previous values.
- Arithmetic, per component, per pixel, unsigned:
  - add: min(c+value, 2^DATA_W-1).
  - sub: max(c-value, 0).
  - invert: (2^DATA_W-1)-c.
  - threshold: all three channels = (Y>value) ? 2^DATA_W-1 : 0. Equality gives 0.
  - gray: all three channels = Y.
- Boundaries:
  - HSYNC_IN in IDLE or DONE: beat is dropped, frame_err is set, and no output is produced.
  - VSYNC_IN in ACTIVE (early frame): frame_err is set, the in-flight pipeline beats still drain out, counters restart, and the new mode and value are latched; state goes to ARMED.
  - VSYNC_IN in DRAIN: the drain completes and frame_done still pulses, then the new frame is treated as ARMED. The new frame's latch happens on the VSYNC cycle.
  - HSYNC_IN in DRAIN: frame_err is set and the beat is dropped.
  - Reset mid-frame: everything is cleared immediately, and no frame_done is produced.
  - HEIGHT=1 and WIDTH=PIX_PER_CLK must work: a single-beat frame goes ARMED→DRAIN directly.

Test Plan:
- WIDTH=8, HEIGHT=2, P=2, mode=0: VSYNC, then 8 consecutive beats with R=G=B=beat index → HSYNC_OUT high for 8 cycles starting 2 cycles after the first beat; data identical; frame_done pulses 3 cycles after the last input beat (LAT+1); line_cnt goes 0→1.
- mode=1, value=100: component 200 → 255, component 50 → 150. mode=2, value=100: component 50 → 0, component 200 → 100.
- mode=4, value=57, R=100, G=50, B=30 (Y=57) → all channels 0. Same pixel with value=56 → all channels 255. mode=5 → all channels 57.
- Gapped input: beats with HSYNC_IN pattern 1,0,0,1,… → output pattern is identical, shifted 2 cycles; col_cnt holds during gaps.
- Change mode from 3 to 0 mid-frame → whole frame stays inverted. The next VSYNC selects pass.
- VSYNC_IN at beat 3 of line 0 → frame_err=1 and the two in-flight beats still appear at the output. HSYNC_IN in IDLE → frame_err=1 and no output. HRESETn low mid-frame → all outputs 0 at once and no frame_done.

Source files
------------

// File: rtl/pixel_stream_proc.sv
// Framed RGB point-operation pipeline: PIX_PER_CLK pixels per beat, fixed two-cycle latency,
// with line/column tracking, a frame-done pulse and a sticky framing-error flag.
module pixel_stream_proc #(
  parameter int DATA_W      = 8,
  parameter int PIX_PER_CLK = 2,
  parameter int WIDTH       = 768,
  parameter int HEIGHT      = 512,
  localparam int BUS_W  = PIX_PER_CLK * DATA_W,
  localparam int BEATS  = WIDTH / PIX_PER_CLK,
  localparam int LINE_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1,
  localparam int COL_W  = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic [2:0]        mode,
  input  logic [DATA_W-1:0] value,
  input  logic              VSYNC_IN,
  input  logic              HSYNC_IN,
  input  logic [BUS_W-1:0]  DATA_R_IN,
  input  logic [BUS_W-1:0]  DATA_G_IN,
  input  logic [BUS_W-1:0]  DATA_B_IN,
  output logic              HSYNC_OUT,
  output logic [BUS_W-1:0]  DATA_R_OUT,
  output logic [BUS_W-1:0]  DATA_G_OUT,
  output logic [BUS_W-1:0]  DATA_B_OUT,
  output logic [LINE_W-1:0] line_cnt,
  output logic [COL_W-1:0]  col_cnt,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err
);

  localparam int                LAT       = 2;
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(BEATS - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(HEIGHT - 1);
  localparam logic [DATA_W-1:0] PIX_MAX   = {DATA_W{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  function automatic logic [DATA_W-1:0] luma(input logic [DATA_W-1:0] r, g, b);
    logic [DATA_W+1:0] sum;
    sum = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
    return sum[DATA_W+1:2];
  endfunction

  function automatic logic [DATA_W-1:0] point_op(input logic [2:0] op,
                                                 input logic [DATA_W-1:0] v, c, y);
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] res;
    sum = {1'b0, c} + {1'b0, v};
    case (op)
      3'd1:    res = sum[DATA_W] ? PIX_MAX : sum[DATA_W-1:0];
      3'd2:    res = (c > v) ? (c - v) : {DATA_W{1'b0}};
      3'd3:    res = PIX_MAX - c;
      3'd4:    res = (y > v) ? PIX_MAX : {DATA_W{1'b0}};
      3'd5:    res = y;
      default: res = c;
    endcase
    return res;
  endfunction

  state_t              state_q, state_d;
  logic [2:0]          mode_q, mode_d;
  logic [DATA_W-1:0]   value_q, value_d;
  logic [LINE_W-1:0]   line_q, line_d, line_nx_s;
  logic [COL_W-1:0]    col_q, col_d, col_nx_s;
  logic [1:0]          drain_q, drain_d;
  logic                err_q, err_d, pend_q, pend_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic                accept_s, frame_last_s;

  logic                s1_vld_q, s1_vld_d;
  logic [BUS_W-1:0]    s1_r_q, s1_r_d, s1_g_q, s1_g_d, s1_b_q, s1_b_d, s1_y_q, s1_y_d;
  logic [2:0]          s1_op_q, s1_op_d;
  logic [DATA_W-1:0]   s1_val_q, s1_val_d;
  logic                hs_q, hs_d;
  logic [BUS_W-1:0]    out_r_q, out_r_d, out_g_q, out_g_d, out_b_q, out_b_d;

  // Position counters as they would be after accepting one more beat.
  always_comb begin
    if (col_q == COL_LAST) begin
      col_nx_s = {COL_W{1'b0}};
      if (line_q == LINE_LAST) begin
        line_nx_s    = {LINE_W{1'b0}};
        frame_last_s = 1'b1;
      end else begin
        line_nx_s    = line_q + LINE_W'(1);
        frame_last_s = 1'b0;
      end
    end else begin
      col_nx_s     = col_q + COL_W'(1);
      line_nx_s    = line_q;
      frame_last_s = 1'b0;
    end
  end

  // Frame FSM: next state, shadow latch, counters and error flag.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    value_d  = value_q;
    line_d   = line_q;
    col_d    = col_q;
    err_d    = err_q;
    pend_d   = pend_q;
    drain_d  = drain_q;
    accept_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (VSYNC_IN) begin
          mode_d  = mode;
          value_d = value;
          line_d  = {LINE_W{1'b0}};
          col_d   = {COL_W{1'b0}};
          err_d   = 1'b0;
          state_d = ST_ARMED;
        end else begin
          err_d = err_q | HSYNC_IN;
        end
      end
      ST_ARMED, ST_ACTIVE: begin
        // A VSYNC wins over a coincident beat; during ACTIVE it marks an early frame.
        if (VSYNC_IN) begin
          mode_d  = mode;
          value_d = value;
          line_d  = {LINE_W{1'b0}};
          col_d   = {COL_W{1'b0}};
          err_d   = err_q | (state_q == ST_ACTIVE);
          state_d = ST_ARMED;
        end else if (HSYNC_IN) begin
          accept_s = 1'b1;
          col_d    = col_nx_s;
          line_d   = line_nx_s;
          drain_d  = 2'd0;
          state_d  = frame_last_s ? ST_DRAIN : ST_ACTIVE;
        end else begin
          state_d = state_q;
        end
      end
      ST_DRAIN: begin
        if (VSYNC_IN) begin
          mode_d  = mode;
          value_d = value;
          pend_d  = 1'b1;
        end else begin
          pend_d = pend_q;
        end
        err_d = err_q | HSYNC_IN;
        if (drain_q == 2'(LAT - 1)) begin
          state_d = ST_DONE;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      ST_DONE: begin
        // A frame started during DRAIN (or right now) resumes in ARMED.
        if (VSYNC_IN || pend_q) begin
          if (VSYNC_IN) begin
            mode_d  = mode;
            value_d = value;
          end else begin
            mode_d = mode_q;
          end
          line_d  = {LINE_W{1'b0}};
          col_d   = {COL_W{1'b0}};
          pend_d  = 1'b0;
          state_d = ST_ARMED;
        end else begin
          state_d = ST_IDLE;
        end
        err_d = HSYNC_IN | (err_q & ~(VSYNC_IN | pend_q));
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_ACTIVE) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
  end

  // Stage 1: capture accepted beat, its luma and the frame's operation.
  always_comb begin
    s1_vld_d = accept_s;
    if (accept_s) begin
      s1_r_d   = DATA_R_IN;
      s1_g_d   = DATA_G_IN;
      s1_b_d   = DATA_B_IN;
      s1_op_d  = mode_q;
      s1_val_d = value_q;
      s1_y_d   = {BUS_W{1'b0}};
      for (int k = 0; k < PIX_PER_CLK; k++) begin
        s1_y_d[k*DATA_W +: DATA_W] = luma(DATA_R_IN[k*DATA_W +: DATA_W],
                                          DATA_G_IN[k*DATA_W +: DATA_W],
                                          DATA_B_IN[k*DATA_W +: DATA_W]);
      end
    end else begin
      s1_r_d   = s1_r_q;
      s1_g_d   = s1_g_q;
      s1_b_d   = s1_b_q;
      s1_op_d  = s1_op_q;
      s1_val_d = s1_val_q;
      s1_y_d   = s1_y_q;
    end
  end

  // Stage 2: apply the point operation; outputs hold between valid beats.
  always_comb begin
    hs_d = s1_vld_q;
    if (s1_vld_q) begin
      out_r_d = {BUS_W{1'b0}};
      out_g_d = {BUS_W{1'b0}};
      out_b_d = {BUS_W{1'b0}};
      for (int k = 0; k < PIX_PER_CLK; k++) begin
        out_r_d[k*DATA_W +: DATA_W] = point_op(s1_op_q, s1_val_q, s1_r_q[k*DATA_W +: DATA_W],
                                               s1_y_q[k*DATA_W +: DATA_W]);
        out_g_d[k*DATA_W +: DATA_W] = point_op(s1_op_q, s1_val_q, s1_g_q[k*DATA_W +: DATA_W],
                                               s1_y_q[k*DATA_W +: DATA_W]);
        out_b_d[k*DATA_W +: DATA_W] = point_op(s1_op_q, s1_val_q, s1_b_q[k*DATA_W +: DATA_W],
                                               s1_y_q[k*DATA_W +: DATA_W]);
      end
    end else begin
      out_r_d = out_r_q;
      out_g_d = out_g_q;
      out_b_d = out_b_q;
    end
  end

  // Control registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      mode_q  <= 3'd0;
      value_q <= {DATA_W{1'b0}};
      line_q  <= {LINE_W{1'b0}};
      col_q   <= {COL_W{1'b0}};
      drain_q <= 2'd0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      value_q <= value_d;
      line_q  <= line_d;
      col_q   <= col_d;
      drain_q <= drain_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Pipeline registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      s1_vld_q <= 1'b0;
      s1_r_q   <= {BUS_W{1'b0}};
      s1_g_q   <= {BUS_W{1'b0}};
      s1_b_q   <= {BUS_W{1'b0}};
      s1_y_q   <= {BUS_W{1'b0}};
      s1_op_q  <= 3'd0;
      s1_val_q <= {DATA_W{1'b0}};
      hs_q     <= 1'b0;
      out_r_q  <= {BUS_W{1'b0}};
      out_g_q  <= {BUS_W{1'b0}};
      out_b_q  <= {BUS_W{1'b0}};
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_r_q   <= s1_r_d;
      s1_g_q   <= s1_g_d;
      s1_b_q   <= s1_b_d;
      s1_y_q   <= s1_y_d;
      s1_op_q  <= s1_op_d;
      s1_val_q <= s1_val_d;
      hs_q     <= hs_d;
      out_r_q  <= out_r_d;
      out_g_q  <= out_g_d;
      out_b_q  <= out_b_d;
    end
  end

  assign HSYNC_OUT  = hs_q;
  assign DATA_R_OUT = out_r_q;
  assign DATA_G_OUT = out_g_q;
  assign DATA_B_OUT = out_b_q;
  assign line_cnt   = line_q;
  assign col_cnt    = col_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_pixel_stream_proc.sv
// Scoreboard bench for pixel_stream_proc on a small 8x2 frame, two pixels per beat.
module tb_pixel_stream_proc;

  localparam int DW = 8, PPC = 2, W = 8, H = 2;
  localparam int BEATS = W / PPC, FRAME_BEATS = BEATS * H;

  logic        HCLK = 1'b0, HRESETn = 1'b0;
  logic [2:0]  mode = 3'd0;
  logic [7:0]  value = 8'd0;
  logic        VSYNC_IN = 1'b0, HSYNC_IN = 1'b0;
  logic [15:0] r_in = 16'd0, g_in = 16'd0, b_in = 16'd0;
  logic        HSYNC_OUT, busy, frame_done, frame_err;
  logic [15:0] r_out, g_out, b_out;
  logic [0:0]  line_cnt;
  logic [1:0]  col_cnt;

  int          n_vec = 0, n_err = 0;
  logic [47:0] sb_q[$];
  logic [47:0] last_exp = 48'd0;
  logic        acc_now = 1'b0;
  logic [1:0]  exp_hs;
  int          model_mode = 0, model_val = 0, k_acc = 0;

  always #5 HCLK = ~HCLK;

  pixel_stream_proc #(.DATA_W(DW), .PIX_PER_CLK(PPC), .WIDTH(W), .HEIGHT(H)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .mode(mode), .value(value),
    .VSYNC_IN(VSYNC_IN), .HSYNC_IN(HSYNC_IN),
    .DATA_R_IN(r_in), .DATA_G_IN(g_in), .DATA_B_IN(b_in),
    .HSYNC_OUT(HSYNC_OUT), .DATA_R_OUT(r_out), .DATA_G_OUT(g_out), .DATA_B_OUT(b_out),
    .line_cnt(line_cnt), .col_cnt(col_cnt), .busy(busy),
    .frame_done(frame_done), .frame_err(frame_err)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_op(input int m, input int v, input int c, input int y);
    case (m)
      1:       return 8'((c + v > 255) ? 255 : c + v);
      2:       return 8'((c > v) ? c - v : 0);
      3:       return 8'(255 - c);
      4:       return (y > v) ? 8'd255 : 8'd0;
      5:       return 8'(y);
      default: return 8'(c);
    endcase
  endfunction

  // Expected output valid: accepted beats delayed by two clocks.
  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) exp_hs <= 2'b00;
    else          exp_hs <= {exp_hs[0], acc_now};
  end

  always @(negedge HCLK) begin
    check_eq("hsync_out", HSYNC_OUT, exp_hs[1]);
    if (!HRESETn) begin
      sb_q.delete();
      last_exp = 48'd0;
    end else if (HSYNC_OUT) begin
      if (sb_q.size() == 0) check_eq("sb_underflow", 64'(sb_q.size()), 64'd1);
      else begin
        last_exp = sb_q.pop_front();
        check_eq("pix_data", {r_out, g_out, b_out}, last_exp);
      end
    end else begin
      check_eq("data_hold", {r_out, g_out, b_out}, last_exp);
    end
  end

  task automatic cycle();
    @(posedge HCLK);
    #1;
  endtask

  task automatic check_pos(input string tag);
    check_eq({tag, "_col"}, col_cnt, 64'(k_acc % BEATS));
    check_eq({tag, "_line"}, line_cnt, 64'((k_acc / BEATS) % H));
  endtask

  task automatic start_frame(input int m, input int v);
    mode = 3'(m); value = 8'(v); VSYNC_IN = 1'b1;
    cycle();
    VSYNC_IN = 1'b0;
    model_mode = m; model_val = v; k_acc = 0;
    check_pos("latch");
  endtask

  // kind 1: every component = idx; kind 2: fixed test pixels; otherwise random.
  task automatic beat(input int kind, input int idx);
    int r, g, b, y;
    logic [15:0] er, eg, eb;
    for (int p = 0; p < PPC; p++) begin
      if (kind == 1) begin r = idx; g = idx; b = idx; end
      else if (kind == 2) begin r = (p == 0) ? 200 : 100; g = 50; b = 30; end
      else begin r = $urandom_range(0, 255); g = $urandom_range(0, 255); b = $urandom_range(0, 255); end
      y = (r + 2 * g + b) / 4;
      r_in[p*8 +: 8] = 8'(r); g_in[p*8 +: 8] = 8'(g); b_in[p*8 +: 8] = 8'(b);
      er[p*8 +: 8] = ref_op(model_mode, model_val, r, y);
      eg[p*8 +: 8] = ref_op(model_mode, model_val, g, y);
      eb[p*8 +: 8] = ref_op(model_mode, model_val, b, y);
    end
    sb_q.push_back({er, eg, eb});
    HSYNC_IN = 1'b1; acc_now = 1'b1;
    cycle();
    HSYNC_IN = 1'b0; acc_now = 1'b0;
    k_acc++;
    check_pos("beat");
  endtask

  task automatic send_frame(input int m, input int v, input int m_after, input int gap,
                            input int kind, input int do_vs);
    if (do_vs != 0) start_frame(m, v);
    mode = 3'(m_after); value = 8'($urandom_range(0, 255));
    for (int i = 0; i < FRAME_BEATS; i++) begin
      beat((kind == 2 && i != 0) ? 0 : kind, i);
      if (gap != 0 && i != FRAME_BEATS - 1) begin
        repeat (2) begin
          cycle();
          check_pos("gap_hold");
        end
      end
    end
  endtask

  // Bounded wait for frame_done; optionally raises VSYNC in the first DRAIN cycle.
  task automatic wait_done(input int vs_in, input int m, input int v);
    int n = 0, hi = 0;
    if (vs_in != 0) begin
      mode = 3'(m); value = 8'(v); VSYNC_IN = 1'b1;
    end
    for (int i = 1; i <= 8; i++) begin
      @(negedge HCLK);
      if (frame_done) begin
        hi++;
        if (n == 0) n = i;
      end
      cycle();
      if (VSYNC_IN) begin
        VSYNC_IN = 1'b0;
        model_mode = m; model_val = v; k_acc = 0;
      end
    end
    check_eq("done_latency", 64'(n), 64'd3);
    check_eq("done_width", 64'(hi), 64'd1);
  endtask

  initial begin
    #3;
    check_eq("rst_hsync", HSYNC_OUT, 1'b0);
    check_eq("rst_data", {r_out, g_out, b_out}, 48'd0);
    check_eq("rst_pos", {line_cnt, col_cnt}, 3'd0);
    check_eq("rst_flags", {busy, frame_done, frame_err}, 3'd0);
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;

    send_frame(0, 0, 0, 0, 1, 1);
    check_eq("busy_drain", busy, 1'b1);
    wait_done(0, 0, 0);
    check_eq("err_clean", frame_err, 1'b0);
    check_eq("idle_busy", busy, 1'b0);

    send_frame(1, 100, 2, 0, 2, 1); wait_done(0, 0, 0);
    send_frame(2, 100, 1, 0, 2, 1); wait_done(0, 0, 0);
    send_frame(4, 57, 5, 0, 2, 1);  wait_done(0, 0, 0);
    send_frame(4, 56, 0, 0, 2, 1);  wait_done(0, 0, 0);
    send_frame(5, 0, 3, 0, 2, 1);   wait_done(0, 0, 0);
    send_frame(3, 0, 0, 0, 0, 1);   wait_done(0, 0, 0);
    send_frame(0, 0, 3, 1, 0, 1);   wait_done(0, 0, 0);

    // VSYNC during DRAIN: done still pulses, next frame inverts without another VSYNC
    send_frame(0, 0, 0, 0, 0, 1);
    wait_done(1, 3, 0);
    check_eq("drain_vs_err", frame_err, 1'b0);
    send_frame(0, 0, 0, 0, 2, 0);
    wait_done(0, 0, 0);

    // beat while IDLE is dropped and flagged
    check_eq("idle_err_pre", frame_err, 1'b0);
    r_in = 16'hA5A5; HSYNC_IN = 1'b1;
    cycle();
    HSYNC_IN = 1'b0;
    repeat (3) cycle();
    check_eq("idle_err", frame_err, 1'b1);
    check_eq("idle_busy2", busy, 1'b0);

    // early VSYNC after three beats of line 0
    start_frame(3, 0);
    check_eq("err_cleared", frame_err, 1'b0);
    for (int i = 0; i < 3; i++) beat(0, i);
    mode = 3'd5; value = 8'd9; VSYNC_IN = 1'b1;
    cycle();
    VSYNC_IN = 1'b0;
    model_mode = 5; model_val = 9; k_acc = 0;
    check_eq("early_err", frame_err, 1'b1);
    check_pos("early_restart");
    check_eq("early_armed", busy, 1'b0);
    send_frame(0, 0, 1, 0, 0, 0);
    wait_done(0, 0, 0);
    check_eq("err_sticky", frame_err, 1'b1);

    // reset in the middle of a frame
    start_frame(1, 10);
    for (int i = 0; i < 3; i++) beat(0, i);
    #2 HRESETn = 1'b0;
    #1;
    check_eq("mid_rst_out", {HSYNC_OUT, r_out, g_out, b_out}, 49'd0);
    check_eq("mid_rst_flags", {busy, frame_done, frame_err, line_cnt, col_cnt}, 6'd0);
    repeat (2) cycle();
    HRESETn = 1'b1;
    k_acc = 0;
    begin
      int seen = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge HCLK);
        if (frame_done) seen++;
      end
      check_eq("no_done_after_rst", 64'(seen), 64'd0);
    end
    check_eq("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
